// File: rtl/irr_pkg.sv
// rtl/irr_pkg.sv - shared types and level-qualify helpers for the irrigation zone controller
package irr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SCAN   = 2'd1,
        ST_WATER  = 2'd2,
        ST_SETTLE = 2'd3
    } state_e;

    typedef enum logic {
        MODE_SPRAY = 1'b0,
        MODE_DRIP  = 1'b1
    } mode_e;

    // Probe masks over {h, m, l}: every masked probe must read wet for the mode to run.
    localparam logic [2:0] QUAL_DRIP  = 3'b001;
    localparam logic [2:0] QUAL_SPRAY = 3'b010;

    function automatic logic level_ok(input mode_e mode, input logic [2:0] hml);
        logic [2:0] q;
        q = (mode == MODE_DRIP) ? QUAL_DRIP : QUAL_SPRAY;
        return (hml & q) == q;
    endfunction

endpackage

// File: rtl/irrigation_zone_controller_if.sv
// rtl/irrigation_zone_controller_if.sv - sensor and valve signal bundle for the irrigation zone controller
// slave  : controller side (sensors in, valves/status out)
// master : environment side (drives sensors, observes valves/status)
interface irrigation_zone_controller_if #(
    parameter int ZONES   = 4,
    parameter int TIMER_W = 8
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;

    logic               h;
    logic               m;
    logic               l;
    logic [ZONES-1:0]   us;
    logic [ZONES-1:0]   ua;
    logic               alarme;
    logic               ValvulaEntrada;
    logic [ZONES-1:0]   drip;
    logic [ZONES-1:0]   spray;
    logic [ZW-1:0]      active_zone;
    logic [TIMER_W-1:0] remaining;
    logic               busy;

    modport slave (
        input  h, m, l, us, ua,
        output alarme, ValvulaEntrada, drip, spray, active_zone, remaining, busy
    );

    modport master (
        output h, m, l, us, ua,
        input  alarme, ValvulaEntrada, drip, spray, active_zone, remaining, busy
    );
endinterface

// File: rtl/irr_tick_gen.sv
// rtl/irr_tick_gen.sv - 1-second tick prescaler
// Ports: clk, rst_n (async active-low), clr (restart count), tick (one-cycle pulse every PRESCALE cycles)
module irr_tick_gen #(
    parameter int PRESCALE = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || (cnt_q == CW'(PRESCALE - 1))) begin
            cnt_d = '0;
        end
    end

    assign tick = (cnt_q == CW'(PRESCALE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/irrigation_zone_controller.sv
// rtl/irrigation_zone_controller.sv - round-robin multi-zone irrigation controller with tank level supervision
// Ports: clk, rst_n (async active-low), bus (slave modport: h/m/l probes, us/ua zone requests,
//        alarme, ValvulaEntrada, drip/spray valves, active_zone, remaining, busy)
// Macro IRR_INLET_HYST_EN: inlet valve uses m-low/h-high hysteresis instead of plain ~h.
module irrigation_zone_controller
    import irr_pkg::*;
#(
    parameter int ZONES      = 4,
    parameter int PRESCALE   = 50000000,
    parameter int TIMER_W    = 8,
    parameter int DRIP_SEC   = 30,
    parameter int SPRAY_SEC  = 15,
    parameter int SETTLE_CYC = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    irrigation_zone_controller_if.slave  bus
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    // Two-flop synchronisers for all sensor inputs
    logic [2:0]       hml_s1_q, hml_s2_q;
    logic [ZONES-1:0] us_s1_q, us_s2_q, ua_s1_q, ua_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hml_s1_q <= '0;
            hml_s2_q <= '0;
            us_s1_q  <= '0;
            us_s2_q  <= '0;
            ua_s1_q  <= '0;
            ua_s2_q  <= '0;
        end else begin
            hml_s1_q <= {bus.h, bus.m, bus.l};
            hml_s2_q <= hml_s1_q;
            us_s1_q  <= bus.us;
            us_s2_q  <= us_s1_q;
            ua_s1_q  <= bus.ua;
            ua_s2_q  <= ua_s1_q;
        end
    end

    logic h_s, m_s, l_s;
    assign h_s = hml_s2_q[2];
    assign m_s = hml_s2_q[1];
    assign l_s = hml_s2_q[0];

    // Registered state
    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [ZW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [ZW-1:0]      zone_q, zone_d;
    logic [SW-1:0]      settle_cnt_q, settle_cnt_d;
    logic [TIMER_W-1:0] remaining_q, remaining_d;
    logic               alarme_q, alarme_d;
    logic               inlet_q, inlet_d;
    logic [ZONES-1:0]   drip_q, drip_d, spray_q, spray_d;
    logic [ZW-1:0]      active_zone_q, active_zone_d;
    logic               busy_q, busy_d;

    logic tick, tick_clr;

    irr_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tick_clr),
        .tick  (tick)
    );

    function automatic logic [ZW-1:0] next_zone(input logic [ZW-1:0] z);
        return (z == ZW'(ZONES - 1)) ? '0 : z + ZW'(1);
    endfunction

    // Probe fault: a wetter probe reads wet while the one below it reads dry
    assign alarme_d = (h_s & ~m_s) | (m_s & ~l_s);

`ifdef IRR_INLET_HYST_EN
    always_comb begin
        inlet_d = inlet_q;
        if (alarme_d) begin
            inlet_d = 1'b0;
        end else if (!m_s) begin
            inlet_d = 1'b1;
        end else if (h_s) begin
            inlet_d = 1'b0;
        end
    end
`else
    assign inlet_d = ~h_s & ~alarme_d;
`endif

    // First requesting zone at or after rr_ptr, wrapping; lowest offset wins.
    logic          found;
    logic [ZW-1:0] sel;
    logic [ZW-1:0] idx;
    mode_e         sel_mode;

    always_comb begin
        found = 1'b0;
        sel   = rr_ptr_q;
        idx   = '0;
        for (int i = ZONES - 1; i >= 0; i--) begin
            idx = ZW'((int'(rr_ptr_q) + i) % ZONES);
            if (us_s2_q[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    assign sel_mode = ua_s2_q[sel] ? MODE_DRIP : MODE_SPRAY;

    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        rr_ptr_d     = rr_ptr_q;
        zone_d       = zone_q;
        settle_cnt_d = settle_cnt_q;
        remaining_d  = remaining_q;
        tick_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((|us_s2_q) && !alarme_q) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (alarme_q || !found) begin
                    state_d = ST_IDLE;
                end else if (level_ok(sel_mode, hml_s2_q)) begin
                    state_d     = ST_WATER;
                    zone_d      = sel;
                    mode_d      = sel_mode;
                    remaining_d = (sel_mode == MODE_DRIP) ? TIMER_W'(DRIP_SEC) : TIMER_W'(SPRAY_SEC);
                    tick_clr    = 1'b1;
                end else begin
                    // Skipped zone still advances the pointer so a low tank cannot pin it.
                    rr_ptr_d = next_zone(sel);
                    state_d  = ST_IDLE;
                end
            end
            ST_WATER: begin
                if (alarme_q || !level_ok(mode_q, hml_s2_q)) begin
                    state_d      = ST_SETTLE;
                    settle_cnt_d = '0;
                    remaining_d  = '0;
                end else if (tick) begin
                    if (remaining_q <= TIMER_W'(1)) begin
                        state_d      = ST_SETTLE;
                        settle_cnt_d = '0;
                        remaining_d  = '0;
                    end else begin
                        remaining_d = remaining_q - TIMER_W'(1);
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q == SW'(SETTLE_CYC - 1)) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_zone(zone_q);
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs derive from the next state so valve and busy rise on the same edge.
    always_comb begin
        drip_d        = '0;
        spray_d       = '0;
        busy_d        = (state_d == ST_WATER) || (state_d == ST_SETTLE);
        active_zone_d = busy_d ? zone_d : '0;
        if (state_d == ST_WATER) begin
            if (mode_d == MODE_DRIP) begin
                drip_d[zone_d] = 1'b1;
            end else begin
                spray_d[zone_d] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            mode_q        <= MODE_SPRAY;
            rr_ptr_q      <= '0;
            zone_q        <= '0;
            settle_cnt_q  <= '0;
            remaining_q   <= '0;
            alarme_q      <= 1'b0;
            inlet_q       <= 1'b0;
            drip_q        <= '0;
            spray_q       <= '0;
            active_zone_q <= '0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            rr_ptr_q      <= rr_ptr_d;
            zone_q        <= zone_d;
            settle_cnt_q  <= settle_cnt_d;
            remaining_q   <= remaining_d;
            alarme_q      <= alarme_d;
            inlet_q       <= inlet_d;
            drip_q        <= drip_d;
            spray_q       <= spray_d;
            active_zone_q <= active_zone_d;
            busy_q        <= busy_d;
        end
    end

    assign bus.alarme         = alarme_q;
    assign bus.ValvulaEntrada = inlet_q;
    assign bus.drip           = drip_q;
    assign bus.spray          = spray_q;
    assign bus.active_zone    = active_zone_q;
    assign bus.remaining      = remaining_q;
    assign bus.busy           = busy_q;
endmodule

// File: tb/tb_irrigation_zone_controller.sv
// tb/tb_irrigation_zone_controller.sv - directed self-checking bench for irrigation_zone_controller
module tb_irrigation_zone_controller;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    int   n;
    int   bad;
    logic [3:0] exp_v;
    logic [3:0] acc;

    always #5 clk = ~clk;

    irrigation_zone_controller_if #(.ZONES(4), .TIMER_W(8)) bus ();

    irrigation_zone_controller #(
        .ZONES(4), .PRESCALE(4), .TIMER_W(8),
        .DRIP_SEC(3), .SPRAY_SEC(2), .SETTLE_CYC(2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int k);
        repeat (k) @(negedge clk);
    endtask

    // Bounded wait for a valve vector; an expired bound shows up as a failed check.
    task automatic wait_valve(input bit is_drip, input logic [3:0] exp, input int limit, input string tag);
        int c;
        c = 0;
        while (((is_drip ? bus.drip : bus.spray) !== exp) && c < limit) begin
            @(negedge clk);
            c++;
        end
        check(tag, is_drip ? bus.drip : bus.spray, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.h = 0; bus.m = 0; bus.l = 0;
        bus.us = '0; bus.ua = '0;
        cyc(2);
        check("rst_alarme", bus.alarme, 0);
        check("rst_inlet", bus.ValvulaEntrada, 0);
        check("rst_drip", bus.drip, 0);
        check("rst_spray", bus.spray, 0);
        check("rst_zone", bus.active_zone, 0);
        check("rst_rem", bus.remaining, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;

        // Single drip zone
        bus.h = 1; bus.m = 1; bus.l = 1;
        cyc(5);
        check("full_alarme", bus.alarme, 0);
        check("full_inlet", bus.ValvulaEntrada, 0);
        bus.us = 4'b0100; bus.ua = 4'b0100;
        wait_valve(1, 4'b0100, 10, "drip_start");
        bus.us = 4'b0000;
        check("drip_busy", bus.busy, 1);
        check("drip_zone", bus.active_zone, 2);
        for (int k = 0; k < 12; k++) begin
            check("drip_on", bus.drip, 4'b0100);
            check("drip_rem", bus.remaining, 3 - k / 4);
            cyc(1);
        end
        check("drip_off", bus.drip, 0);
        check("settle1_busy", bus.busy, 1);
        check("settle_rem", bus.remaining, 0);
        cyc(1);
        check("settle2_busy", bus.busy, 1);
        cyc(1);
        check("idle_busy", bus.busy, 0);
        check("idle_zone", bus.active_zone, 0);

        // Round-robin spray across all zones from a fresh pointer
        do_reset();
        cyc(3);
        bus.us = 4'b1111; bus.ua = 4'b0000;
        bad = 0;
        for (int s = 0; s < 5; s++) begin
            exp_v = 4'b0001 << (s % 4);
            wait_valve(0, exp_v, 30, "rr_start");
            check("rr_zone", bus.active_zone, s % 4);
            n = 0;
            while (bus.spray === exp_v && n < 20) begin
                if (bus.drip !== 4'b0 || $countones(bus.spray) > 1) bad++;
                n++;
                cyc(1);
            end
            check("rr_len", n, 8);
        end
        check("rr_onehot", bad, 0);

        // Abort on loss of m while spraying zone 1
        wait_valve(0, 4'b0010, 30, "abort_start");
        check("abort_rem", bus.remaining, 2);
        bus.h = 0; bus.m = 0; bus.l = 1;
        n = 0;
        while (bus.spray !== 4'b0 && n < 6) begin
            cyc(1);
            n++;
        end
        check("abort_latency_le3", (n <= 3), 1);
        check("abort_settle_busy", bus.busy, 1);
        check("abort_alarme", bus.alarme, 0);
        cyc(3);
        acc = '0;
        bad = 0;
        for (int k = 0; k < 30; k++) begin
            acc |= bus.spray | bus.drip;
            if (bus.busy !== 1'b0) bad++;
            cyc(1);
        end
        check("skip_no_valve", acc, 0);
        check("skip_not_busy", bad, 0);
        bus.ua = 4'b0100;
        wait_valve(1, 4'b0100, 40, "skip_then_drip");
        check("skip_drip_zone", bus.active_zone, 2);
        bus.us = 4'b0000;
        n = 0;
        while (bus.busy !== 1'b0 && n < 40) begin
            cyc(1);
            n++;
        end
        check("drain_idle", bus.busy, 0);

        // Probe fault h=1, m=0
        bus.h = 1; bus.m = 0; bus.l = 1;
        cyc(2);
        check("fault_pre", bus.alarme, 0);
        cyc(1);
        check("fault_alarme", bus.alarme, 1);
        check("fault_inlet", bus.ValvulaEntrada, 0);
        bus.us = 4'b1111; bus.ua = 4'b1111;
        cyc(10);
        check("fault_busy", bus.busy, 0);
        check("fault_drip", bus.drip, 0);
        check("fault_spray", bus.spray, 0);
        bus.h = 1; bus.m = 1; bus.l = 1;
        cyc(3);
        check("fault_clear", bus.alarme, 0);
        bus.us = 4'b0000;

        // Inlet valve across rising levels and back down
        @(negedge clk);
        rst_n = 1'b0;
        bus.h = 0; bus.m = 0; bus.l = 0;
        bus.us = '0; bus.ua = '0;
        @(negedge clk);
        rst_n = 1'b1;
        cyc(4);
        check("inlet_000", bus.ValvulaEntrada, 1);
        bus.l = 1;
        cyc(4);
        check("inlet_l", bus.ValvulaEntrada, 1);
        bus.m = 1;
        cyc(4);
        check("inlet_lm", bus.ValvulaEntrada, 1);
        check("inlet_lm_alarme", bus.alarme, 0);
        bus.h = 1;
        cyc(4);
        check("inlet_lmh", bus.ValvulaEntrada, 0);
        bus.h = 0;
        cyc(4);
`ifdef IRR_INLET_HYST_EN
        check("inlet_back_lm", bus.ValvulaEntrada, 0);
`else
        check("inlet_back_lm", bus.ValvulaEntrada, 1);
`endif

        // Reset in the middle of watering
        bus.h = 1;
        cyc(3);
        bus.us = 4'b0001; bus.ua = 4'b0001;
        wait_valve(1, 4'b0001, 15, "rstmid_start");
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("rstmid_drip", bus.drip, 0);
        check("rstmid_busy", bus.busy, 0);
        check("rstmid_rem", bus.remaining, 0);
        check("rstmid_zone", bus.active_zone, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        check("rstrel_drip", bus.drip, 0);
        check("rstrel_busy", bus.busy, 0);
        wait_valve(1, 4'b0001, 15, "rstrel_resume");
        bus.us = 4'b0000;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/irrigation_zone_controller.md
IRRIGATION_ZONE_CONTROLLER -- requirements
Module: irrigation_zone_controller

Interface
REQ-001 Parameter ZONES, default 4, number of independently watered zones (1..16).
REQ-002 Parameter PRESCALE, default 50000000, clk cycles per 1-second tick (>=2).
REQ-003 Parameter TIMER_W, default 8, width of the watering countdown in seconds.
REQ-004 Parameter DRIP_SEC, default 30, drip duration in seconds (1..2^TIMER_W-1).
REQ-005 Parameter SPRAY_SEC, default 15, sprinkler duration in seconds (1..2^TIMER_W-1).
REQ-006 Parameter SETTLE_CYC, default 8, valve dead-time in clk cycles between zones (>=1).
REQ-007 clk  in  1  single system clock, rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 h, m, l  in  1 each  tank level probes (high, mid, low); 1 = wet.
REQ-010 us  in  ZONES  per-zone soil-dry request; 1 = zone needs water.
REQ-011 ua  in  ZONES  per-zone air-dry flag; 1 = drip mode, 0 = spray mode.
REQ-012 alarme  out  1  registered level-probe fault.
REQ-013 ValvulaEntrada  out  1  registered tank inlet valve.
REQ-014 drip, spray  out  ZONES each  registered zone valves; at most one bit set across both vectors.
REQ-015 active_zone  out  $clog2(ZONES) (min 1)  zone being watered, 0 when idle.
REQ-016 remaining  out  TIMER_W  seconds left in current watering, 0 when idle.
REQ-017 busy  out  1  high in WATER and SETTLE.

Function
REQ-018 All sensor inputs SHALL pass a 2-flop synchroniser; "sampled" below means post-synchroniser.
REQ-019 alarme SHALL be set one cycle after sampled (h&~m)|(m&~l) and clear one cycle after it is false.
REQ-020 A one-cycle tick SHALL pulse every PRESCALE cycles; prescaler SHALL restart on entry to WATER.
REQ-021 FSM states: IDLE, SCAN, WATER, SETTLE.
REQ-022 IDLE->SCAN when any sampled us bit is 1 and alarme=0.
REQ-023 SCAN SHALL select, in one cycle, the first zone with us=1 starting at rr_ptr and wrapping at ZONES-1->0; it SHALL go to WATER if the level qualifies (drip needs l, spray needs m), else mark the zone skipped and return to IDLE.
REQ-024 On WATER entry, mode SHALL latch from ua, remaining SHALL load DRIP_SEC or SPRAY_SEC, and the matching valve bit SHALL assert on the same cycle as busy.
REQ-025 In WATER, remaining SHALL decrement on each tick; on reaching 0 the valve SHALL drop and the FSM SHALL enter SETTLE.
REQ-026 WATER SHALL abort to SETTLE on alarme=1 or loss of the mode's level probe, regardless of remaining; us falling SHALL NOT abort.
REQ-027 SETTLE SHALL hold all valves off for SETTLE_CYC cycles, advance rr_ptr to served zone+1 (wrapping), then go to IDLE.
REQ-028 A zone that is skipped in SCAN SHALL also advance rr_ptr, so a dry tank cannot starve other zones.
REQ-029 Any transition to alarme=1 in IDLE or SCAN SHALL force IDLE with all zone valves off.
REQ-030 ValvulaEntrada SHALL be 0 whenever alarme=1.

Reset
REQ-031 Reset SHALL clear FSM to IDLE, rr_ptr, prescaler, synchronisers, and all outputs to 0.
REQ-032 Reset asserted mid-WATER SHALL close the valve asynchronously; no state is retained.

Configuration
REQ-033 Macro IRR_INLET_HYST_EN defined: ValvulaEntrada sets when sampled m=0 and clears only when sampled h=1.
REQ-034 Macro IRR_INLET_HYST_EN undefined: ValvulaEntrada = registered (~h & ~alarme), with no hysteresis.

Structure
REQ-035 Package irr_pkg SHALL hold the FSM state enum, the mode enum (DRIP, SPRAY), and level-qualify helper constants.
REQ-036 The prescaler SHALL be a sub-module irr_tick_gen (params PRESCALE; ports clk, rst_n, clr, tick).

Verification (ZONES=4, PRESCALE=4, DRIP_SEC=3, SPRAY_SEC=2, SETTLE_CYC=2, hysteresis on)
REQ-037 Single drip zone: h=m=l=1, us=0100, ua=0100 -> drip=0100 for 12 cycles, remaining 3->2->1->0, 2 dead cycles, then active_zone returns 0.
REQ-038 Round-robin: us=1111, ua=0000 -> zones served 0,1,2,3,0, each with spray for 8 cycles; never two valves on.
REQ-039 Abort: spraying zone 1, drop m (h=0, l=1) at remaining=2 -> spray clears within 3 cycles of the input edge, SETTLE, then next SCAN skips spray zones.
REQ-040 Fault: h=1, m=0 -> alarme=1 after 3 cycles, ValvulaEntrada=0, all valves off; restoring h=m=l=1 clears alarme.
REQ-041 Hysteresis: levels 000->l->lm->lmh -> inlet on from 000 until h=1; then lowering to lm keeps inlet off.
REQ-042 Reset mid-WATER: assert rst_n=0 during drip -> drip=0 immediately; all outputs stay 0 until us is re-sampled.
